eth_arp_responder: RTL and testbench

ETH_ARP_RESPONDER -- requirements
Module: eth_arp_responder

---
 rtl/eth_arp_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_eth_arp_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_arp_responder.sv
`default_nettype none
// ============================================================================
//  Module      : eth_arp_responder
//  Description : Drains received Ethernet frames from the rx data/ctl FIFOs,
//                recognises ARP requests for the local IPv4 address and queues
//                a 60-byte ARP reply (plus length word) into the tx FIFOs.
//  Revision    : 1.0  initial release
// ============================================================================
module eth_arp_responder #(
  parameter int PAD_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [47:0] local_mac_in,
  input  logic [31:0] local_ip_in,
  output logic        data_rd_en_out,
  input  logic [8:0]  data_rd_d_in,
  input  logic        data_rd_empty_in,
  output logic        ctl_rd_en_out,
  input  logic [17:0] ctl_rd_d_in,
  input  logic        ctl_rd_empty_in,
  output logic        data_wr_en_out,
  output logic [8:0]  data_wr_d_out,
  input  logic        data_wr_full_in,
  output logic        ctl_wr_en_out,
  output logic [17:0] ctl_wr_d_out,
  input  logic        ctl_wr_full_in,
  output logic [15:0] reply_count_out,
  output logic        busy_out
);

  localparam logic [15:0] c_LEN      = 16'(PAD_LEN);
  localparam logic [5:0]  c_LAST     = 6'(PAD_LEN - 1);
  localparam logic [10:0] c_IDX_MAX  = 11'h7FF;
  localparam logic [10:0] c_MIN_LAST = 11'd41;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX_DATA = 3'd1,
    S_RX_CTL  = 3'd2,
    S_CHECK   = 3'd3,
    S_TX_DATA = 3'd4,
    S_TX_CTL  = 3'd5
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic         r_data_vld;   // rx data dout holds a fresh byte this cycle
  logic         r_ctl_req;    // ctl word already requested for this frame
  logic         r_ctl_vld;    // rx ctl dout holds a fresh word this cycle
  logic [10:0]  r_idx;        // rx byte index, saturating
  logic         r_dst_bc;     // destination so far all FF
  logic         r_dst_uc;     // destination so far equals local MAC
  logic         r_hdr_ok;     // ethertype and ARP fixed header match
  logic         r_tpa_ok;     // target protocol address equals local IP
  logic         r_len_ok;     // last byte index reached at least 41
  logic         r_err;        // error flag from the ctl word
  logic [47:0]  r_sha;
  logic [31:0]  r_spa;
  logic [5:0]   r_tx_idx;
  logic [15:0]  r_count;

  logic [7:0]   w_rx_byte;
  logic         w_rx_last;
  logic         w_match;
  logic [7:0]   w_tx_byte;
  logic [3:0]   w_hdr_k;
  logic [1:0]   w_tpa_k;

  // Only the error bit of the rx ctl word matters; length and reserved bits are ignored.
  wire w_unused = &{1'b0, ctl_rd_d_in[17], ctl_rd_d_in[15:0]};

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] k);
    case (k)
      3'd0:    mac_byte = m[47:40];
      3'd1:    mac_byte = m[39:32];
      3'd2:    mac_byte = m[31:24];
      3'd3:    mac_byte = m[23:16];
      3'd4:    mac_byte = m[15:8];
      3'd5:    mac_byte = m[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [1:0] k);
    case (k)
      2'd0:    ip_byte = a[31:24];
      2'd1:    ip_byte = a[23:16];
      2'd2:    ip_byte = a[15:8];
      default: ip_byte = a[7:0];
    endcase
  endfunction

  // Bytes 12..21 of an ARP-over-Ethernet frame; only the oper low byte differs.
  function automatic logic [7:0] arp_hdr_byte(input logic [3:0] k, input logic reply);
    case (k)
      4'd0:    arp_hdr_byte = 8'h08;
      4'd1:    arp_hdr_byte = 8'h06;
      4'd2:    arp_hdr_byte = 8'h00;
      4'd3:    arp_hdr_byte = 8'h01;
      4'd4:    arp_hdr_byte = 8'h08;
      4'd5:    arp_hdr_byte = 8'h00;
      4'd6:    arp_hdr_byte = 8'h06;
      4'd7:    arp_hdr_byte = 8'h04;
      4'd8:    arp_hdr_byte = 8'h00;
      4'd9:    arp_hdr_byte = reply ? 8'h02 : 8'h01;
      default: arp_hdr_byte = 8'h00;
    endcase
  endfunction

  assign w_rx_byte = data_rd_d_in[7:0];
  // A last byte is visible the same cycle it is consumed so no extra read is issued.
  assign w_rx_last = r_data_vld & data_rd_d_in[8];
  assign w_hdr_k   = 4'(r_idx - 11'd12);
  assign w_tpa_k   = 2'(r_idx - 11'd38);
  assign w_match   = enable_in & ~r_err & r_len_ok & (r_dst_bc | r_dst_uc) & r_hdr_ok & r_tpa_ok;

  assign reply_count_out = r_count;
  assign busy_out        = (r_state != S_IDLE);

  // Reply byte generator, addressed by the tx byte index.
  always_comb begin
    w_tx_byte = 8'h00;
    if (r_tx_idx < 6'd6)
      w_tx_byte = mac_byte(r_sha, r_tx_idx[2:0]);
    else if (r_tx_idx < 6'd12)
      w_tx_byte = mac_byte(local_mac_in, 3'(r_tx_idx - 6'd6));
    else if (r_tx_idx < 6'd22)
      w_tx_byte = arp_hdr_byte(4'(r_tx_idx - 6'd12), 1'b1);
    else if (r_tx_idx < 6'd28)
      w_tx_byte = mac_byte(local_mac_in, 3'(r_tx_idx - 6'd22));
    else if (r_tx_idx < 6'd32)
      w_tx_byte = ip_byte(local_ip_in, 2'(r_tx_idx - 6'd28));
    else if (r_tx_idx < 6'd38)
      w_tx_byte = mac_byte(r_sha, 3'(r_tx_idx - 6'd32));
    else if (r_tx_idx < 6'd42)
      w_tx_byte = ip_byte(r_spa, 2'(r_tx_idx - 6'd38));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and FIFO handshake outputs.
  always_comb begin
    w_next         = r_state;
    data_rd_en_out = 1'b0;
    ctl_rd_en_out  = 1'b0;
    data_wr_en_out = 1'b0;
    data_wr_d_out  = 9'd0;
    ctl_wr_en_out  = 1'b0;
    ctl_wr_d_out   = 18'd0;
    case (r_state)
      S_IDLE: begin
        if (!data_rd_empty_in) w_next = S_RX_DATA;
      end
      S_RX_DATA: begin
        data_rd_en_out = ~data_rd_empty_in & ~w_rx_last;
        if (w_rx_last) w_next = S_RX_CTL;
      end
      S_RX_CTL: begin
        ctl_rd_en_out = ~ctl_rd_empty_in & ~r_ctl_req;
        if (r_ctl_vld) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_next = w_match ? S_TX_DATA : S_IDLE;
      end
      S_TX_DATA: begin
        data_wr_en_out = ~data_wr_full_in;
        data_wr_d_out  = {(r_tx_idx == c_LAST), w_tx_byte};
        if (!data_wr_full_in && (r_tx_idx == c_LAST)) w_next = S_TX_CTL;
      end
      S_TX_CTL: begin
        ctl_wr_en_out = ~ctl_wr_full_in;
        ctl_wr_d_out  = {2'b00, c_LEN};
        if (!ctl_wr_full_in) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Receive parsing, field capture, tx index and reply counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_vld <= 1'b0;
      r_ctl_req  <= 1'b0;
      r_ctl_vld  <= 1'b0;
      r_idx      <= 11'd0;
      r_dst_bc   <= 1'b0;
      r_dst_uc   <= 1'b0;
      r_hdr_ok   <= 1'b0;
      r_tpa_ok   <= 1'b0;
      r_len_ok   <= 1'b0;
      r_err      <= 1'b0;
      r_sha      <= 48'd0;
      r_spa      <= 32'd0;
      r_tx_idx   <= 6'd0;
      r_count    <= 16'd0;
    end else begin
      r_data_vld <= data_rd_en_out;
      r_ctl_vld  <= ctl_rd_en_out;
      r_ctl_req  <= (r_state == S_RX_CTL) & (r_ctl_req | ctl_rd_en_out);

      if (r_state == S_IDLE) begin
        r_idx    <= 11'd0;
        r_dst_bc <= 1'b1;
        r_dst_uc <= 1'b1;
        r_hdr_ok <= 1'b1;
        r_tpa_ok <= 1'b1;
        r_len_ok <= 1'b0;
      end else if (r_data_vld) begin
        if (r_idx < 11'd6) begin
          if (w_rx_byte != 8'hFF) r_dst_bc <= 1'b0;
          if (w_rx_byte != mac_byte(local_mac_in, r_idx[2:0])) r_dst_uc <= 1'b0;
        end else if (r_idx >= 11'd12 && r_idx < 11'd22) begin
          if (w_rx_byte != arp_hdr_byte(w_hdr_k, 1'b0)) r_hdr_ok <= 1'b0;
        end else if (r_idx >= 11'd22 && r_idx < 11'd28) begin
          r_sha <= {r_sha[39:0], w_rx_byte};
        end else if (r_idx >= 11'd28 && r_idx < 11'd32) begin
          r_spa <= {r_spa[23:0], w_rx_byte};
        end else if (r_idx >= 11'd38 && r_idx < 11'd42) begin
          if (w_rx_byte != ip_byte(local_ip_in, w_tpa_k)) r_tpa_ok <= 1'b0;
        end
        if (data_rd_d_in[8]) r_len_ok <= (r_idx >= c_MIN_LAST);
        if (r_idx != c_IDX_MAX) r_idx <= r_idx + 11'd1;
      end

      if (r_ctl_vld) r_err <= ctl_rd_d_in[16];

      if (r_state == S_TX_DATA) begin
        if (!data_wr_full_in) r_tx_idx <= r_tx_idx + 6'd1;
      end else begin
        r_tx_idx <= 6'd0;
      end

      if (ctl_wr_en_out) r_count <= r_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_arp_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_arp_responder
//  Description : Self-checking bench for eth_arp_responder with behavioural
//                rx/tx FIFO models and a reply scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eth_arp_responder;

  localparam logic [47:0] MAC = 48'h02_11_22_33_44_55;
  localparam logic [31:0] IP  = 32'hC0_A8_01_0A;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_in = 1'b1;
  logic [47:0] local_mac_in = MAC;
  logic [31:0] local_ip_in = IP;
  logic        data_rd_en_out;
  logic [8:0]  data_rd_d_in = 9'd0;
  logic        data_rd_empty_in = 1'b1;
  logic        ctl_rd_en_out;
  logic [17:0] ctl_rd_d_in = 18'd0;
  logic        ctl_rd_empty_in = 1'b1;
  logic        data_wr_en_out;
  logic [8:0]  data_wr_d_out;
  logic        data_wr_full_in = 1'b0;
  logic        ctl_wr_en_out;
  logic [17:0] ctl_wr_d_out;
  logic        ctl_wr_full_in = 1'b0;
  logic [15:0] reply_count_out;
  logic        busy_out;

  always #5 clk = ~clk;

  eth_arp_responder #(.PAD_LEN(60)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in),
    .local_mac_in(local_mac_in), .local_ip_in(local_ip_in),
    .data_rd_en_out(data_rd_en_out), .data_rd_d_in(data_rd_d_in), .data_rd_empty_in(data_rd_empty_in),
    .ctl_rd_en_out(ctl_rd_en_out), .ctl_rd_d_in(ctl_rd_d_in), .ctl_rd_empty_in(ctl_rd_empty_in),
    .data_wr_en_out(data_wr_en_out), .data_wr_d_out(data_wr_d_out), .data_wr_full_in(data_wr_full_in),
    .ctl_wr_en_out(ctl_wr_en_out), .ctl_wr_d_out(ctl_wr_d_out), .ctl_wr_full_in(ctl_wr_full_in),
    .reply_count_out(reply_count_out), .busy_out(busy_out)
  );

  logic [8:0]  rxq[$];
  logic [17:0] ctlq[$];
  logic [8:0]  act_data[$];
  logic [17:0] act_ctl[$];
  logic [8:0]  exp_data[$];
  logic [17:0] exp_ctl[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_viol = 0;
  logic [15:0] exp_count = 16'd0;

  // Standard-read FIFO models and tx write capture.
  always @(posedge clk) begin
    if (rst) begin
      rxq.delete();
      ctlq.delete();
      data_rd_d_in     <= 9'd0;
      ctl_rd_d_in      <= 18'd0;
      data_rd_empty_in <= 1'b1;
      ctl_rd_empty_in  <= 1'b1;
    end else begin
      if (data_rd_en_out) begin
        if (rxq.size() == 0) n_viol++;
        else data_rd_d_in <= rxq.pop_front();
      end
      if (ctl_rd_en_out) begin
        if (ctlq.size() == 0) n_viol++;
        else ctl_rd_d_in <= ctlq.pop_front();
      end
      data_rd_empty_in <= (rxq.size() == 0);
      ctl_rd_empty_in  <= (ctlq.size() == 0);
      if (data_wr_en_out) begin
        if (data_wr_full_in) n_viol++;
        act_data.push_back(data_wr_d_out);
      end
      if (ctl_wr_en_out) begin
        if (ctl_wr_full_in) n_viol++;
        act_ctl.push_back(ctl_wr_d_out);
      end
    end
  end

  task automatic push_frame(input logic [47:0] dst, input logic [47:0] sha, input logic [31:0] spa,
                            input logic [31:0] tpa, input int len, input bit err);
    logic [7:0] b [0:63];
    logic [7:0] hdr [0:9];
    hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      b[k]      = dst[47-8*k -: 8];
      b[6 + k]  = sha[47-8*k -: 8];
      b[22 + k] = sha[47-8*k -: 8];
    end
    for (int k = 0; k < 10; k++) b[12 + k] = hdr[k];
    for (int k = 0; k < 4; k++) begin
      b[28 + k] = spa[31-8*k -: 8];
      b[38 + k] = tpa[31-8*k -: 8];
    end
    for (int i = 0; i < len; i++) rxq.push_back({(i == len - 1), b[i]});
    ctlq.push_back({1'b0, err, 16'(len)});
  endtask

  task automatic exp_reply(input logic [47:0] sha, input logic [31:0] spa);
    logic [7:0] r [0:59];
    logic [7:0] hdr [0:9];
    hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    for (int i = 0; i < 60; i++) r[i] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      r[k]      = sha[47-8*k -: 8];
      r[6 + k]  = MAC[47-8*k -: 8];
      r[22 + k] = MAC[47-8*k -: 8];
      r[32 + k] = sha[47-8*k -: 8];
    end
    for (int k = 0; k < 10; k++) r[12 + k] = hdr[k];
    for (int k = 0; k < 4; k++) begin
      r[28 + k] = IP[31-8*k -: 8];
      r[38 + k] = spa[31-8*k -: 8];
    end
    for (int i = 0; i < 60; i++) exp_data.push_back({(i == 59), r[i]});
    exp_ctl.push_back(18'h0003C);
    exp_count++;
  endtask

  // Waits for the DUT to drain the rx FIFOs and return to idle; optional tx back-pressure.
  task automatic wait_idle(input int budget, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      data_wr_full_in = toggle && (c % 3 == 0);
      if (rxq.size() == 0 && ctlq.size() == 0 && !busy_out && data_rd_empty_in && ctl_rd_empty_in) begin
        ok = 1'b1;
        break;
      end
    end
    data_wr_full_in = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({data_rd_en_out, ctl_rd_en_out, data_wr_en_out, ctl_wr_en_out} !== 4'b0) begin n_bad++; $display("FAIL reset_en got %b want 0000", {data_rd_en_out, ctl_rd_en_out, data_wr_en_out, ctl_wr_en_out}); end
    n_cmp++; if (data_wr_d_out !== 9'd0) begin n_bad++; $display("FAIL reset_data_d got %h want 000", data_wr_d_out); end
    n_cmp++; if (ctl_wr_d_out !== 18'd0) begin n_bad++; $display("FAIL reset_ctl_d got %h want 00000", ctl_wr_d_out); end
    n_cmp++; if (reply_count_out !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", reply_count_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_out); end
  endtask

  // Sends one request, optionally with tx back-pressure, and scores the reply stream.
  task automatic test_reply(input string name, input logic [47:0] dst, input bit toggle);
    bit ok;
    logic [8:0] a, e;
    logic [17:0] ac, ec;
    push_frame(dst, 48'hA0_B1_C2_D3_E4_F5, 32'h0A_00_00_01, IP, 60, 1'b0);
    exp_reply(48'hA0_B1_C2_D3_E4_F5, 32'h0A_00_00_01);
    wait_idle(1000, toggle, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout got busy want idle", name); end
    n_cmp++; if (act_data.size() != exp_data.size()) begin n_bad++; $display("FAIL %s_nbytes got %0d want %0d", name, act_data.size(), exp_data.size()); end
    while (act_data.size() > 0 && exp_data.size() > 0) begin
      a = act_data.pop_front(); e = exp_data.pop_front();
      n_cmp++; if (a !== e) begin n_bad++; $display("FAIL %s_byte got %h want %h", name, a, e); end
    end
    n_cmp++; if (act_ctl.size() != exp_ctl.size()) begin n_bad++; $display("FAIL %s_nctl got %0d want %0d", name, act_ctl.size(), exp_ctl.size()); end
    while (act_ctl.size() > 0 && exp_ctl.size() > 0) begin
      ac = act_ctl.pop_front(); ec = exp_ctl.pop_front();
      n_cmp++; if (ac !== ec) begin n_bad++; $display("FAIL %s_ctl got %h want %h", name, ac, ec); end
    end
    n_cmp++; if (reply_count_out !== exp_count) begin n_bad++; $display("FAIL %s_count got %0d want %0d", name, reply_count_out, exp_count); end
    act_data.delete(); act_ctl.delete(); exp_data.delete(); exp_ctl.delete();
  endtask

  // Frames that must be drained without any reply.
  task automatic test_reject(input string name, input logic [31:0] tpa, input int len, input bit err, input bit en);
    bit ok;
    enable_in = en;
    push_frame(BC, 48'h00_0C_29_AA_BB_CC, 32'h0A_00_00_07, tpa, len, err);
    wait_idle(1000, 1'b0, ok);
    enable_in = 1'b1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout got busy want idle", name); end
    n_cmp++; if (act_data.size() != 0) begin n_bad++; $display("FAIL %s_txbytes got %0d want 0", name, act_data.size()); end
    n_cmp++; if (act_ctl.size() != 0) begin n_bad++; $display("FAIL %s_txctl got %0d want 0", name, act_ctl.size()); end
    n_cmp++; if (reply_count_out !== exp_count) begin n_bad++; $display("FAIL %s_count got %0d want %0d", name, reply_count_out, exp_count); end
    act_data.delete(); act_ctl.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [8:0] a, e;
    logic [17:0] ac, ec;
    push_frame(BC, 48'h11_22_33_44_55_66, 32'h0A_01_02_03, IP, 60, 1'b0);
    push_frame(MAC, 48'h66_55_44_33_22_11, 32'h0A_04_05_06, IP, 64, 1'b0);
    exp_reply(48'h11_22_33_44_55_66, 32'h0A_01_02_03);
    exp_reply(48'h66_55_44_33_22_11, 32'h0A_04_05_06);
    wait_idle(2000, 1'b0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout got busy want idle"); end
    n_cmp++; if (act_data.size() != 120) begin n_bad++; $display("FAIL b2b_nbytes got %0d want 120", act_data.size()); end
    while (act_data.size() > 0 && exp_data.size() > 0) begin
      a = act_data.pop_front(); e = exp_data.pop_front();
      n_cmp++; if (a !== e) begin n_bad++; $display("FAIL b2b_byte got %h want %h", a, e); end
    end
    while (act_ctl.size() > 0 && exp_ctl.size() > 0) begin
      ac = act_ctl.pop_front(); ec = exp_ctl.pop_front();
      n_cmp++; if (ac !== ec) begin n_bad++; $display("FAIL b2b_ctl got %h want %h", ac, ec); end
    end
    n_cmp++; if (exp_ctl.size() != 0 || act_ctl.size() != 0) begin n_bad++; $display("FAIL b2b_nctl got %0d left want 0", exp_ctl.size() + act_ctl.size()); end
    n_cmp++; if (reply_count_out !== exp_count) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", reply_count_out, exp_count); end
    act_data.delete(); act_ctl.delete(); exp_data.delete(); exp_ctl.delete();
  endtask

  task automatic test_mid_reset();
    int c;
    push_frame(BC, 48'hA0_B1_C2_D3_E4_F5, 32'h0A_00_00_01, IP, 60, 1'b0);
    c = 0;
    while (act_data.size() < 20 && c < 1000) begin @(negedge clk); c++; end
    n_cmp++; if (act_data.size() < 20) begin n_bad++; $display("FAIL midrst_reach got %0d bytes want 20", act_data.size()); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({data_rd_en_out, ctl_rd_en_out, data_wr_en_out, ctl_wr_en_out} !== 4'b0) begin n_bad++; $display("FAIL midrst_en got %b want 0000", {data_rd_en_out, ctl_rd_en_out, data_wr_en_out, ctl_wr_en_out}); end
    n_cmp++; if (data_wr_d_out !== 9'd0 || ctl_wr_d_out !== 18'd0) begin n_bad++; $display("FAIL midrst_d got %h/%h want 0/0", data_wr_d_out, ctl_wr_d_out); end
    n_cmp++; if (reply_count_out !== 16'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", reply_count_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy_out); end
    rst = 1'b0;
    act_data.delete(); act_ctl.delete(); exp_data.delete(); exp_ctl.delete();
    exp_count = 16'd0;
    repeat (20) @(negedge clk);
    n_cmp++; if (act_data.size() != 0 || act_ctl.size() != 0) begin n_bad++; $display("FAIL midrst_quiet got %0d writes want 0", act_data.size() + act_ctl.size()); end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reply("bcast", BC, 1'b0);
    test_reject("err", IP, 60, 1'b1, 1'b1);
    test_reject("tpa", 32'hC0_A8_01_0B, 60, 1'b0, 1'b1);
    test_reject("disabled", IP, 60, 1'b0, 1'b0);
    test_reject("trunc", IP, 30, 1'b0, 1'b1);
    test_reply("after_trunc", BC, 1'b0);
    test_reply("unicast", MAC, 1'b0);
    test_reply("backpressure", BC, 1'b1);
    test_back_to_back();
    test_mid_reset();
    test_reply("post_reset", BC, 1'b0);
    n_cmp++; if (n_viol != 0) begin n_bad++; $display("FAIL fifo_protocol got %0d violations want 0", n_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
